// File: rtl/vid_gen.sv
// Atom display path: 640x480@60 VGA timing with mode 4 / mode 3 graphics
// rendered as a 512x384 picture centred in a black border.
module vid_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        gm,
   input  logic        css,
   output logic [12:0] vid_addr,
   input  logic [7:0]  vid_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic        fs_n
);

   localparam logic [9:0] H_LAST    = 10'd799;
   localparam logic [9:0] H_VIS     = 10'd640;
   localparam logic [9:0] H_SYNC_S  = 10'd656;
   localparam logic [9:0] H_SYNC_E  = 10'd752;
   localparam logic [9:0] V_LAST    = 10'd524;
   localparam logic [9:0] V_VIS     = 10'd480;
   localparam logic [9:0] V_SYNC_S  = 10'd490;
   localparam logic [9:0] V_SYNC_E  = 10'd492;
   localparam logic [9:0] WIN_X0    = 10'd64;
   localparam logic [9:0] WIN_X1    = 10'd576;
   localparam logic [9:0] WIN_Y0    = 10'd48;
   localparam logic [9:0] WIN_Y1    = 10'd432;
   // Fetch runs 8 clocks ahead of the picture so each byte is on vid_data
   // well before its load slot, one clock ahead of the first pixel render.
   localparam logic [9:0] FETCH_X0  = 10'd56;
   localparam logic [9:0] FETCH_X1  = 10'd568;
   localparam logic [9:0] LOAD_X0   = 10'd65;
   localparam logic [9:0] LOAD_X1   = 10'd562;
   localparam logic [9:0] RENDER_X0 = 10'd66;

   logic [9:0]  h;
   logic [9:0]  v;
   logic        gm_line;
   logic        css_line;

   logic        v_in_win;
   logic        fetch_en;
   logic        load_en;
   logic        shift_en;
   logic [7:0]  src_line;
   logic [4:0]  byte_col;
   logic [3:0]  load_ph;
   logic [1:0]  pix_ph;

   logic        de_s1, hs_s1, vs_s1, fs_s1, win_s1;
   logic        de_s2, hs_s2, vs_s2, fs_s2, win_s2;
   logic [7:0]  shreg;
   logic [11:0] pix_rgb;

   always_ff @(posedge clk) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
         h <= h + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gm_line  <= 1'b0;
         css_line <= 1'b0;
      end else if (h == 10'd0) begin
         gm_line  <= gm;
         css_line <= css;
      end
   end

   assign v_in_win = (v >= WIN_Y0) && (v < WIN_Y1);
   assign src_line = 8'((v - WIN_Y0) >> 1);
   assign byte_col = 5'((h - FETCH_X0) >> 4);
   assign load_ph  = 4'(h - LOAD_X0);
   assign pix_ph   = 2'(h - RENDER_X0);

   assign fetch_en = v_in_win && (h >= FETCH_X0) && (h < FETCH_X1);
   assign load_en  = v_in_win && (h >= LOAD_X0) && (h < LOAD_X1) && (load_ph == 4'd0);
   assign shift_en = gm_line ? (pix_ph == 2'b11) : pix_ph[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         vid_addr <= '0;
      end else if (fetch_en) begin
         vid_addr <= {src_line, byte_col};
      end
   end

   // Stage 1: timing decode of the counter position.
   always_ff @(posedge clk) begin
      if (reset) begin
         de_s1  <= 1'b0;
         hs_s1  <= 1'b1;
         vs_s1  <= 1'b1;
         fs_s1  <= 1'b1;
         win_s1 <= 1'b0;
      end else begin
         de_s1  <= (h < H_VIS) && (v < V_VIS);
         hs_s1  <= !((h >= H_SYNC_S) && (h < H_SYNC_E));
         vs_s1  <= !((v >= V_SYNC_S) && (v < V_SYNC_E));
         fs_s1  <= (v < WIN_Y1);
         win_s1 <= (h >= WIN_X0) && (h < WIN_X1) && v_in_win;
      end
   end

   // Stage 2: delay to line up with the shift register contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         de_s2  <= 1'b0;
         hs_s2  <= 1'b1;
         vs_s2  <= 1'b1;
         fs_s2  <= 1'b1;
         win_s2 <= 1'b0;
      end else begin
         de_s2  <= de_s1;
         hs_s2  <= hs_s1;
         vs_s2  <= vs_s1;
         fs_s2  <= fs_s1;
         win_s2 <= win_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
      end else if (load_en) begin
         shreg <= vid_data;
      end else if (shift_en) begin
         shreg <= gm_line ? {shreg[5:0], 2'b00} : {shreg[6:0], 1'b0};
      end
   end

   always_comb begin
      pix_rgb = 12'h000;
      if (!gm_line) begin
         if (shreg[7]) begin
            pix_rgb = css_line ? 12'hFFF : 12'h0F0;
         end
      end else begin
         case ({css_line, shreg[7:6]})
            3'b000:  pix_rgb = 12'h0F0;
            3'b001:  pix_rgb = 12'hFF0;
            3'b010:  pix_rgb = 12'h00F;
            3'b011:  pix_rgb = 12'hF00;
            3'b100:  pix_rgb = 12'hFFF;
            3'b101:  pix_rgb = 12'h0FF;
            3'b110:  pix_rgb = 12'hF0F;
            default: pix_rgb = 12'hF80;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vga_r  <= '0;
         vga_g  <= '0;
         vga_b  <= '0;
         vga_de <= 1'b0;
         vga_hs <= 1'b1;
         vga_vs <= 1'b1;
         fs_n   <= 1'b1;
      end else begin
         vga_r  <= win_s2 ? pix_rgb[11:8] : 4'h0;
         vga_g  <= win_s2 ? pix_rgb[7:4]  : 4'h0;
         vga_b  <= win_s2 ? pix_rgb[3:0]  : 4'h0;
         vga_de <= de_s2;
         vga_hs <= hs_s2;
         vga_vs <= vs_s2;
         fs_n   <= fs_s2;
      end
   end

endmodule
